// File: rtl/taxi_axi_rd_outstanding_ctrl_pkg.sv
// taxi_axi_rd_ctrl_pkg: shared state type for the AXI read outstanding controller
package taxi_axi_rd_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} rd_ctrl_state_t;
endpackage

// File: rtl/taxi_axi_rd_outstanding_ctrl_if.sv
// taxi_axi_if: AXI4 read-path (AR + R) signal bundle with master/slave modports
interface taxi_axi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W = 8
);
  logic [ID_W-1:0] arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [ID_W-1:0] rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport rd_mst (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input arready, rid, rdata, rresp, rlast, rvalid
  );
  modport rd_slv (
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/taxi_axi_rd_outstanding_ctrl_wdt.sv
// taxi_axi_rd_ctrl_wdt: saturating no-progress timer, expired when the next count hits LIMIT
module taxi_axi_rd_ctrl_wdt #(
  parameter int LIMIT = 1024,
  localparam int W = LIMIT > 0 ? $clog2(LIMIT + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] tmr_q, tmr_d;
  always_comb tmr_d = clr ? '0 : (en && tmr_q != W'(LIMIT)) ? tmr_q + W'(1) : tmr_q;
  assign expired = tmr_d == W'(LIMIT);
  always_ff @(posedge clk or posedge rst)
    if (rst) tmr_q <= '0;
    else tmr_q <= tmr_d;
endmodule

// File: rtl/taxi_axi_rd_outstanding_ctrl.sv
// taxi_axi_rd_outstanding_ctrl: AXI4 read issue gate limiting in-flight bursts with drain handshake and watchdog
module taxi_axi_rd_outstanding_ctrl
  import taxi_axi_rd_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT = 1024,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic rst,
  taxi_axi_if.rd_slv s_axi_rd,
  taxi_axi_if.rd_mst m_axi_rd,
  input  logic drain_req,
  output logic drain_ack,
  output logic [CNT_W-1:0] outstanding,
  output logic busy,
  output logic timeout_err,
  output logic underflow_err,
  input  logic err_clr,
  output logic stat_issue,
  output logic stat_done
);
  rd_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic terr_q, terr_d, uf_q, uf_d, si_q, sd_q;
  logic blk, iss, beat, done, expired;
  assign blk = state_q != RUN || cnt_q == CNT_W'(MAX_OUTSTANDING);
  assign m_axi_rd.arvalid = s_axi_rd.arvalid & ~blk;
  assign s_axi_rd.arready = m_axi_rd.arready & ~blk;
  assign m_axi_rd.arid = s_axi_rd.arid;
  assign m_axi_rd.araddr = s_axi_rd.araddr;
  assign m_axi_rd.arlen = s_axi_rd.arlen;
  assign m_axi_rd.arsize = s_axi_rd.arsize;
  assign m_axi_rd.arburst = s_axi_rd.arburst;
  assign s_axi_rd.rid = m_axi_rd.rid;
  assign s_axi_rd.rdata = m_axi_rd.rdata;
  assign s_axi_rd.rresp = m_axi_rd.rresp;
  assign s_axi_rd.rlast = m_axi_rd.rlast;
  assign s_axi_rd.rvalid = m_axi_rd.rvalid;
  assign m_axi_rd.rready = s_axi_rd.rready;
  assign iss = m_axi_rd.arvalid & m_axi_rd.arready;
  assign beat = m_axi_rd.rvalid & m_axi_rd.rready;
  assign done = beat & m_axi_rd.rlast;
  always_comb begin
    cnt_d = (iss & ~done) ? cnt_q + CNT_W'(1) : (done & ~iss & cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    uf_d = (done & ~iss & cnt_q == '0) | (uf_q & ~err_clr);
    terr_d = expired | (terr_q & ~err_clr);
    state_d = state_q == RUN ? (drain_req ? DRAIN : RUN) :
              state_q == DRAIN ? (!drain_req ? RUN : cnt_d == '0 ? DRAINED : DRAIN) :
              (drain_req ? DRAINED : RUN);
  end
  if (TIMEOUT > 0) begin : g_wdt
    taxi_axi_rd_ctrl_wdt #(.LIMIT(TIMEOUT)) u_wdt (
      .clk(clk),
      .rst(rst),
      .clr(beat | err_clr | ~busy),
      .en(busy),
      .expired(expired)
    );
  end else begin : g_no_wdt
    assign expired = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      terr_q <= 1'b0;
      uf_q <= 1'b0;
      si_q <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      terr_q <= terr_d;
      uf_q <= uf_d;
      si_q <= iss;
      sd_q <= done;
    end
  assign drain_ack = state_q == DRAINED;
  assign outstanding = cnt_q;
  assign busy = cnt_q != '0;
  assign timeout_err = terr_q;
  assign underflow_err = uf_q;
  assign stat_issue = si_q;
  assign stat_done = sd_q;
endmodule

// File: tb/tb_taxi_axi_rd_outstanding_ctrl.sv
// tb_taxi_axi_rd_outstanding_ctrl: directed and random checks of the read issue gate against a behavioural model
module tb_taxi_axi_rd_outstanding_ctrl;
  localparam int MAX = 4;
  localparam int TO = 8;
  localparam int M_RUN = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic drain_req, err_clr, drain_ack, busy, terr, uf, si, sd;
  logic [2:0] outstanding;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int m_cnt = 0;
  int m_idle = 0;
  int m_mode = M_RUN;
  bit m_terr = 1'b0;
  bit m_uf = 1'b0;
  bit m_si = 1'b0;
  bit m_sd = 1'b0;
  taxi_axi_if s_if ();
  taxi_axi_if m_if ();
  taxi_axi_rd_outstanding_ctrl #(.MAX_OUTSTANDING(MAX), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .s_axi_rd(s_if),
    .m_axi_rd(m_if),
    .drain_req(drain_req),
    .drain_ack(drain_ack),
    .outstanding(outstanding),
    .busy(busy),
    .timeout_err(terr),
    .underflow_err(uf),
    .err_clr(err_clr),
    .stat_issue(si),
    .stat_done(sd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic bit m_allow();
    return m_mode == M_RUN && m_cnt < MAX;
  endfunction
  initial forever begin
    bit iss, beat, done;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_cnt = 0; m_idle = 0; m_mode = M_RUN;
      m_terr = 0; m_uf = 0; m_si = 0; m_sd = 0;
    end else begin
      iss = m_allow() && s_if.arvalid && m_if.arready;
      beat = m_if.rvalid && s_if.rready;
      done = beat && m_if.rlast;
      m_uf = (done && !iss && m_cnt == 0) || (m_uf && !err_clr);
      m_idle = (beat || m_cnt == 0 || err_clr) ? 0 : (m_idle < TO ? m_idle + 1 : m_idle);
      m_terr = (m_idle == TO) || (m_terr && !err_clr);
      m_cnt = m_cnt + int'(iss) - int'(done);
      if (m_cnt < 0) m_cnt = 0;
      if (m_mode == M_RUN) m_mode = drain_req ? M_DRAIN : M_RUN;
      else if (m_mode == M_DRAIN) m_mode = !drain_req ? M_RUN : (m_cnt == 0 ? M_DONE : M_DRAIN);
      else m_mode = drain_req ? M_DONE : M_RUN;
      m_si = iss;
      m_sd = done;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("outstanding", 32'(outstanding), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("s_arready", 32'(s_if.arready), 32'(m_if.arready && m_allow()));
    chk("m_arvalid", 32'(m_if.arvalid), 32'(s_if.arvalid && m_allow()));
    chk("drain_ack", 32'(drain_ack), 32'(m_mode == M_DONE));
    chk("timeout_err", 32'(terr), 32'(m_terr));
    chk("underflow_err", 32'(uf), 32'(m_uf));
    chk("stat_issue", 32'(si), 32'(m_si));
    chk("stat_done", 32'(sd), 32'(m_sd));
    chk("araddr", m_if.araddr, s_if.araddr);
    chk("arid", 32'(m_if.arid), 32'(s_if.arid));
    chk("arlen", 32'(m_if.arlen), 32'(s_if.arlen));
    chk("rdata", s_if.rdata, m_if.rdata);
    chk("rid", 32'(s_if.rid), 32'(m_if.rid));
    chk("rresp", 32'(s_if.rresp), 32'(m_if.rresp));
    chk("rlast", 32'(s_if.rlast), 32'(m_if.rlast));
    chk("rvalid", 32'(s_if.rvalid), 32'(m_if.rvalid));
    chk("rready", 32'(m_if.rready), 32'(s_if.rready));
  end
  initial begin
    drain_req = 1'b1; err_clr = 1'b0;
    s_if.arvalid = 1'b0; s_if.arid = '0; s_if.araddr = 32'h1000; s_if.arlen = 8'd3;
    s_if.arsize = 3'd2; s_if.arburst = 2'd1; s_if.rready = 1'b1;
    m_if.arready = 1'b1; m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    m_if.rdata = '0; m_if.rid = '0; m_if.rresp = '0;
    chk_en = 1'b1;
    #1 rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    chk("boot_ack_c1", 32'(drain_ack), 0);
    step(1);
    chk("boot_ack_c2", 32'(drain_ack), 1);
    drain_req = 1'b0;
    step(1);
    chk("boot_ack_drop", 32'(drain_ack), 0);
    s_if.arvalid = 1'b1;
    step(6);
    chk("t1_cnt4", 32'(outstanding), 4);
    chk("t1_blocked", 32'(s_if.arready), 0);
    for (int b = 0; b < 4; b++) begin
      m_if.rvalid = 1'b1; m_if.rlast = b == 3; m_if.rdata = 32'hA500 + 32'(b);
      step(1);
    end
    m_if.rvalid = 1'b0;
    chk("t1_cnt3", 32'(outstanding), 3);
    chk("t1_reopen", 32'(s_if.arready), 1);
    step(1);
    chk("t1_cnt_refill", 32'(outstanding), 4);
    chk("t1_stat_issue", 32'(si), 1);
    s_if.arvalid = 1'b0;
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1;
    step(2);
    chk("t2_cnt2", 32'(outstanding), 2);
    s_if.arvalid = 1'b1;
    step(1);
    chk("t2_cnt_hold", 32'(outstanding), 2);
    chk("t2_si", 32'(si), 1);
    chk("t2_sd", 32'(sd), 1);
    m_if.rvalid = 1'b0;
    step(1);
    chk("t3_cnt3", 32'(outstanding), 3);
    s_if.arvalid = 1'b0; drain_req = 1'b1;
    step(1);
    s_if.arvalid = 1'b1;
    #1;
    chk("t3_gate_s", 32'(s_if.arready), 0);
    chk("t3_gate_m", 32'(m_if.arvalid), 0);
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1;
    step(3);
    m_if.rvalid = 1'b0;
    chk("t3_cnt0", 32'(outstanding), 0);
    chk("t3_ack", 32'(drain_ack), 1);
    drain_req = 1'b0;
    step(1);
    chk("t3_ack_drop", 32'(drain_ack), 0);
    chk("t3_resume", 32'(s_if.arready), 1);
    step(1);
    s_if.arvalid = 1'b0;
    chk("t4_cnt1", 32'(outstanding), 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("t4_clr0", 32'(terr), 0);
    step(7);
    chk("t4_pre", 32'(terr), 0);
    step(1);
    chk("t4_set", 32'(terr), 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("t4_cleared", 32'(terr), 0);
    m_if.rvalid = 1'b1; m_if.rlast = 1'b0;
    step(1);
    m_if.rvalid = 1'b0;
    step(7);
    chk("t4_pre2", 32'(terr), 0);
    step(1);
    chk("t4_set2", 32'(terr), 1);
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1;
    step(1);
    m_if.rvalid = 1'b0; err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("t4_idle_clr", 32'(terr), 0);
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1;
    step(1);
    chk("t5_uf", 32'(uf), 1);
    chk("t5_cnt0", 32'(outstanding), 0);
    err_clr = 1'b1;
    step(1);
    chk("t5_set_wins", 32'(uf), 1);
    m_if.rvalid = 1'b0;
    step(1);
    err_clr = 1'b0;
    chk("t5_clr", 32'(uf), 0);
    s_if.arvalid = 1'b1;
    step(2);
    s_if.arvalid = 1'b0;
    chk("t6_cnt2", 32'(outstanding), 2);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_cnt", 32'(outstanding), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_run", 32'(s_if.arready), 1);
    step(1);
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      s_if.arvalid = $urandom_range(0, 1) == 1;
      s_if.araddr = $urandom;
      s_if.arid = 8'($urandom);
      s_if.arlen = 8'($urandom);
      m_if.arready = $urandom_range(0, 3) != 0;
      m_if.rvalid = $urandom_range(0, 1) == 1;
      m_if.rlast = $urandom_range(0, 2) == 0;
      m_if.rdata = $urandom;
      m_if.rid = 8'($urandom);
      m_if.rresp = 2'($urandom);
      s_if.rready = $urandom_range(0, 3) != 0;
      err_clr = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      step(1);
    end
    step(1);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
